count8_ctrl: RTL and testbench
==============================

Name: count8_ctrl

Overview:
- Programmable 8-bit up/down counter with run/stop control FSM and terminal-count detection.
- Sits directly downstream of the async-assert/sync-deassert reset stage. Its RESET input is driven by that stage's AASD_RESET output.
- Provides the counting core of the 8-bit counter datapath: start/stop control, parallel load, terminal-count pulse and a sticky overflow flag.

Parameters:
- WIDTH, 8: counter width in bits.
- INIT_VAL, 0: value COUNT takes at reset and on START from DONE.

Ports:
- CLK, input, 1: rising-edge clock.
- RESET, input, 1: asynchronous, active-low reset. Driven by the AASD synchronizer; deassertion is already synchronous to CLK.
- START, input, 1: level sampled each cycle; begins or resumes counting.
- STOP, input, 1: level sampled each cycle; halts counting and returns to IDLE.
- LOAD, input, 1: parallel load strobe.
- LOAD_VAL, input, WIDTH: value written to COUNT on LOAD.
- UP_DN, input, 1: direction; 1 = increment, 0 = decrement.
- EN, input, 1: per-cycle count enable, honoured only in RUN.
- TC_VAL, input, WIDTH: terminal-count compare value.
- COUNT, output, WIDTH: registered counter value.
- TC, output, 1: registered one-cycle terminal-count pulse.
- RUNNING, output, 1: high while the FSM is in RUN.
- OVF, output, 1: sticky wrap/overflow flag.

Behaviour:
- Reset (RESET=0, asynchronous)
  - State = IDLE, COUNT = INIT_VAL, TC = 0, RUNNING = 0, OVF = 0.
  - Outputs hold these values until the first rising CLK edge after RESET returns high.
- States: IDLE, RUN, DONE. RUNNING = 1 only in RUN (decoded from the state register, no extra latency).
- Per-edge priority: STOP > LOAD > START > count step.
- STOP
  - Any state goes to IDLE. COUNT is held and TC = 0.
  - If STOP and START are asserted in the same cycle, STOP wins.
- LOAD (when STOP=0)
  - COUNT <= LOAD_VAL and OVF <= 0. State is unchanged and no count step occurs that cycle.
  - A loaded value equal to TC_VAL does not raise TC.
- IDLE + START: go to RUN. COUNT is unchanged (resume). OVF is cleared.
- DONE + START: go to RUN. COUNT <= INIT_VAL. OVF is cleared.
- RUN, count step (EN=1)
  - COUNT <= COUNT+1 if UP_DN=1, else COUNT-1.
  - With EN=0, COUNT is held and the state is unchanged.
- Terminal count
  - If the stepped next value equals TC_VAL: at the same edge TC <= 1 and state <= DONE.
  - TC returns to 0 on the next edge. TC is never high for two consecutive cycles.
- DONE: COUNT is held and EN is ignored.
- Wrap (default)
  - Up from 2^WIDTH-1 wraps to 0, and down from 0 wraps to 2^WIDTH-1.
  - OVF <= 1 at the wrap edge and stays high until LOAD, START or reset.
- Simultaneous events: wrap and terminal count on the same edge (e.g. TC_VAL=0, counting up from 255) set both OVF and TC and enter DONE.
- Mid-operation reset: RESET low in any state immediately forces the reset values. There is no partial-count recovery.
- All arithmetic is unsigned modulo 2^WIDTH.

Optional Feature:
- Macro: CNT_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping. An up step at 2^WIDTH-1 or a down step at 0 leaves COUNT unchanged and sets OVF <= 1.
  - The terminal-count compare uses the saturated value, so TC fires only if the value actually changes to TC_VAL.
- Undefined: wrap-around behaviour as in Behaviour.

Test Plan:
- Reset: hold RESET=0 for 3 cycles, release -> COUNT=0, TC=0, RUNNING=0, OVF=0. Assert RESET=0 mid-RUN with COUNT=0x25 -> COUNT=0 and RUNNING=0 immediately, without waiting for a CLK edge.
- Up count to terminal: TC_VAL=5, UP_DN=1, EN=1, pulse START -> COUNT steps 1..5, TC high exactly one cycle with COUNT=5, RUNNING falls at that edge, COUNT holds 5.
- Down wrap: LOAD_VAL=1, LOAD, UP_DN=0, TC_VAL=0xFD, START, EN=1 -> COUNT 0, 0xFF (OVF=1), 0xFE, 0xFD with TC pulse. With CNT_SATURATE_EN -> COUNT sticks at 0, OVF=1, TC never fires.
- Priority: in RUN at COUNT=0x10, assert STOP+LOAD(0x80)+START together -> state IDLE, COUNT=0x10. Next cycle LOAD alone -> COUNT=0x80, OVF=0.
- EN gating and resume: RUN with EN toggling 1,0,0,1 from COUNT=0x20 up -> COUNT 0x21, 0x21, 0x21, 0x22. STOP then START -> resumes from 0x22.
- Restart from DONE: after TC at COUNT=5 (INIT_VAL=0), pulse START -> COUNT=0, RUNNING=1, counts up again.

Source files
------------

// File: rtl/count8_ctrl.sv
//-----------------------------------------------------------------------------
// count8_ctrl
//
// Programmable up/down counter with an IDLE/RUN/DONE control FSM, a parallel
// load, a one-cycle terminal-count pulse and a sticky overflow flag.
//
// Optional build macro:
//   CNT_SATURATE_EN - when defined, the counter saturates at 0 / 2^WIDTH-1
//                     instead of wrapping. OVF still flags the attempted wrap.
//                     TC fires only when the value really changes to TC_VAL.
//
// Ports:
//   CLK      in   rising-edge clock
//   RESET    in   asynchronous active-low reset (deassertion already
//                 synchronised to CLK upstream)
//   START    in   begin (from DONE: restart at INIT_VAL) or resume counting
//   STOP     in   halt and return to IDLE, COUNT held
//   LOAD     in   parallel load of LOAD_VAL, clears OVF
//   LOAD_VAL in   [WIDTH] value for LOAD
//   UP_DN    in   1 = increment, 0 = decrement
//   EN       in   per-cycle count enable, used only in RUN
//   TC_VAL   in   [WIDTH] terminal-count compare value
//   COUNT    out  [WIDTH] registered counter value
//   TC       out  registered one-cycle terminal-count pulse
//   RUNNING  out  high while in RUN
//   OVF      out  sticky wrap/overflow flag
//
// Event priority at each edge: STOP > LOAD > START > count step.
// START only acts from IDLE or DONE; asserted while already in RUN it has no
// effect, so the normal count step still happens.
//-----------------------------------------------------------------------------
module count8_ctrl #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             STOP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             UP_DN,
    input  logic             EN,
    input  logic [WIDTH-1:0] TC_VAL,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             RUNNING,
    output logic             OVF
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg, tc_next;
    logic             ovf_reg, ovf_next;

    logic [WIDTH-1:0] step_val;   // value after one step in the current direction
    logic             at_limit;   // this step would cross the 0 / max boundary
    logic             step_hit;   // this step lands on TC_VAL

    //-------------------------------------------------------------------------
    // Step arithmetic
    //-------------------------------------------------------------------------
    always_comb begin
        at_limit = UP_DN ? (count_reg == MAX_VAL) : (count_reg == '0);
        step_val = UP_DN ? (count_reg + WIDTH'(1)) : (count_reg - WIDTH'(1));
`ifdef CNT_SATURATE_EN
        // Saturated step leaves the value alone, so it can never newly reach
        // TC_VAL at the boundary.
        if (at_limit) begin
            step_val = count_reg;
        end
        step_hit = !at_limit && (step_val == TC_VAL);
`else
        step_hit = (step_val == TC_VAL);
`endif
    end

    //-------------------------------------------------------------------------
    // FSM: state register
    //-------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (STOP) begin
            state_next = ST_IDLE;
        end else if (!LOAD) begin
            if (START && (state_reg != ST_RUN)) begin
                state_next = ST_RUN;
            end else if ((state_reg == ST_RUN) && EN && step_hit) begin
                state_next = ST_DONE;
            end
        end
        // Unused encoding recovers to IDLE.
        if (!(state_reg inside {ST_IDLE, ST_RUN, ST_DONE})) begin
            state_next = ST_IDLE;
        end
    end

    //-------------------------------------------------------------------------
    // FSM: output decode
    //-------------------------------------------------------------------------
    always_comb begin
        RUNNING = (state_reg == ST_RUN);
    end

    //-------------------------------------------------------------------------
    // Datapath next values
    //-------------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        tc_next    = 1'b0;          // TC is a pulse: cleared unless set below
        ovf_next   = ovf_reg;
        if (!STOP) begin
            if (LOAD) begin
                count_next = LOAD_VAL;
                ovf_next   = 1'b0;
            end else if (START && (state_reg != ST_RUN)) begin
                ovf_next = 1'b0;
                if (state_reg == ST_DONE) begin
                    count_next = INIT_VAL;
                end
            end else if ((state_reg == ST_RUN) && EN) begin
                count_next = step_val;
                tc_next    = step_hit;
                if (at_limit) begin
                    ovf_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_reg <= INIT_VAL;
            tc_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            tc_reg    <= tc_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign COUNT = count_reg;
    assign TC    = tc_reg;
    assign OVF   = ovf_reg;

endmodule

// File: tb/tb_count8_ctrl.sv
//-----------------------------------------------------------------------------
// tb_count8_ctrl
//
// Directed scenarios followed by randomized stimulus, all checked each cycle
// against a behavioural model of the counter (plain integer arithmetic with
// running/done flags). One line is printed per transaction.
//-----------------------------------------------------------------------------
module tb_count8_ctrl;

`ifdef CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int INIT = 0;

    logic       clk;
    logic       rst_n;
    logic       start, stop, load, up_dn, en;
    logic [7:0] load_val, tc_val;
    logic [7:0] count;
    logic       tc, running, ovf;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Behavioural model state
    int m_cnt;
    bit m_run, m_done, m_tc, m_ovf;

    count8_ctrl #(.WIDTH(8), .INIT_VAL(8'd0)) dut (
        .CLK     (clk),
        .RESET   (rst_n),
        .START   (start),
        .STOP    (stop),
        .LOAD    (load),
        .LOAD_VAL(load_val),
        .UP_DN   (up_dn),
        .EN      (en),
        .TC_VAL  (tc_val),
        .COUNT   (count),
        .TC      (tc),
        .RUNNING (running),
        .OVF     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        $display("[%0t] %s count=0x%02h tc=%0b run=%0b ovf=%0b", $time, tag, count, tc, running, ovf);
        check({tag, "/count"},   32'(count),   32'(m_cnt));
        check({tag, "/tc"},      32'(tc),      32'(m_tc));
        check({tag, "/running"}, 32'(running), 32'(m_run));
        check({tag, "/ovf"},     32'(ovf),     32'(m_ovf));
    endtask

    task automatic model_reset();
        m_cnt  = INIT;
        m_run  = 1'b0;
        m_done = 1'b0;
        m_tc   = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Effect of one rising edge under the current inputs.
    task automatic model_edge();
        int nxt;
        m_tc = 1'b0;
        if (stop) begin
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (load) begin
            m_cnt = int'(load_val);
            m_ovf = 1'b0;
        end else if (start && !m_run) begin
            if (m_done) m_cnt = INIT;
            m_run  = 1'b1;
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_run && en) begin
            nxt = up_dn ? m_cnt + 1 : m_cnt - 1;
            if (nxt > 255 || nxt < 0) begin
                m_ovf = 1'b1;
                nxt   = SAT ? m_cnt : (nxt + 256) % 256;
            end
            if (nxt != m_cnt && nxt == int'(tc_val)) begin
                m_tc   = 1'b1;
                m_run  = 1'b0;
                m_done = 1'b1;
            end
            m_cnt = nxt;
        end
    endtask

    task automatic drv(input bit s, input bit l, input logic [7:0] lv, input bit st,
                       input bit u, input bit e, input logic [7:0] tv);
        stop = s; load = l; load_val = lv; start = st; up_dn = u; en = e; tc_val = tv;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges: outputs must change without a clock edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        int d;
        rst_n = 1'b0;
        drv(0, 0, 8'h00, 0, 1, 0, 8'h00);
        model_reset();

        // Reset held for three cycles, then released
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        rst_n = 1'b1;
        #1;
        check_all("rst_rel");

        // Up count to terminal value 5
        drv(0, 0, 8'h00, 1, 1, 1, 8'h05);
        cycle("up_start");
        start = 1'b0;
        for (int i = 1; i <= 5; i++) cycle("up_step");
        check("up_tc_pulse", 32'(tc), 32'd1);
        check("up_tc_count", 32'(count), 32'd5);
        cycle("up_hold");
        check("up_tc_drop", 32'(tc), 32'd0);
        check("up_hold_count", 32'(count), 32'd5);

        // Restart from DONE
        start = 1'b1;
        cycle("restart");
        check("restart_count", 32'(count), 32'd0);
        start = 1'b0;
        cycle("restart_step");

        // Down count through the wrap
        drv(1, 0, 8'h00, 0, 0, 0, 8'hFD);
        cycle("dn_stop");
        drv(0, 1, 8'h01, 0, 0, 0, 8'hFD);
        cycle("dn_load");
        drv(0, 0, 8'h00, 1, 0, 0, 8'hFD);
        cycle("dn_start");
        drv(0, 0, 8'h00, 0, 0, 1, 8'hFD);
        cycle("dn_step0");
        cycle("dn_wrap");
        check("dn_wrap_ovf", 32'(ovf), 32'd1);
`ifdef CNT_SATURATE_EN
        check("dn_sat_count", 32'(count), 32'h00);
        cycle("dn_sat1");
        cycle("dn_sat2");
        check("dn_sat_no_tc", 32'(tc), 32'd0);
`else
        check("dn_wrap_count", 32'(count), 32'hFF);
        cycle("dn_fe");
        cycle("dn_fd");
        check("dn_tc_pulse", 32'(tc), 32'd1);
        check("dn_tc_count", 32'(count), 32'hFD);
`endif

        // Priority: STOP beats LOAD and START
        drv(1, 0, 8'h00, 0, 1, 0, 8'h05);
        cycle("pri_stop");
        drv(0, 1, 8'h10, 0, 1, 0, 8'h05);
        cycle("pri_load");
        drv(0, 0, 8'h00, 1, 1, 0, 8'h05);
        cycle("pri_start");
        drv(1, 1, 8'h80, 1, 1, 0, 8'h05);
        cycle("pri_all");
        check("pri_all_count", 32'(count), 32'h10);
        check("pri_all_idle", 32'(running), 32'd0);
        drv(0, 1, 8'h80, 0, 1, 0, 8'h05);
        cycle("pri_load2");
        check("pri_load2_count", 32'(count), 32'h80);

        // EN gating and resume
        drv(0, 1, 8'h20, 0, 1, 0, 8'h05);
        cycle("en_load");
        drv(0, 0, 8'h00, 1, 1, 0, 8'h05);
        cycle("en_start");
        start = 1'b0;
        en = 1'b1; cycle("en_1");
        en = 1'b0; cycle("en_0a");
        en = 1'b0; cycle("en_0b");
        en = 1'b1; cycle("en_1b");
        check("en_gate_count", 32'(count), 32'h22);
        drv(1, 0, 8'h00, 0, 1, 0, 8'h05);
        cycle("en_stop");
        drv(0, 0, 8'h00, 1, 1, 0, 8'h05);
        cycle("en_resume");
        check("en_resume_count", 32'(count), 32'h22);
        drv(0, 0, 8'h00, 0, 1, 1, 8'h05);
        cycle("en_resume_step");

        // Mid-RUN reset with COUNT=0x25
        drv(0, 1, 8'h25, 0, 1, 0, 8'h05);
        cycle("mid_load");
        load = 1'b0;
        async_reset("mid_rst");

        // Randomized stimulus
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                up_dn  = 1'($urandom_range(0, 1));
                d      = int'($urandom_range(1, 6));
                tc_val = 8'(m_cnt + (up_dn ? d : -d));
            end
            stop  = ($urandom_range(0, 15) == 0);
            load  = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0:       load_val = 8'h00;
                1:       load_val = 8'hFF;
                2:       load_val = 8'h01;
                3:       load_val = 8'hFE;
                default: load_val = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
